// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider sequencer for the EX stage (DIV/DIVU).
// Optional DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.

// state  | meaning
// IDLE   | waiting for a divide from EX
// BYZERO | divisor was zero, loading the fixed by-zero result
// RUN    | one quotient bit per cycle
// DONE   | result valid for one cycle, ready_o high
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic               stallreq_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BYZERO, RUN, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   dvd_raw;
  logic               neg_q;
  logic               neg_r;
  logic               ready_q;
  logic [2*WIDTH-1:0] result_q;

  logic               div_zero;
  logic               early_out;
  logic               sign_dvd;
  logic               sign_dvs;
  logic [WIDTH-1:0]   mag_dvd;
  logic [WIDTH-1:0]   mag_dvs;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    div_zero = (opdata2_i == '0);
    sign_dvd = signed_i & opdata1_i[WIDTH-1];
    sign_dvs = signed_i & opdata2_i[WIDTH-1];
    mag_dvd  = sign_dvd ? -opdata1_i : opdata1_i;
    mag_dvs  = sign_dvs ? -opdata2_i : opdata2_i;
`ifdef DIV_EARLY_OUT_EN
    early_out = !div_zero && (mag_dvd < mag_dvs);
`else
    early_out = 1'b0;
`endif

    // rem < dvs always holds, so the top bit of a WIDTH+1 bit difference is its sign
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = (quo << 1) | {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = quo << 1;
    end

    quo_fix = neg_q ? -quo_next : quo_next;
    rem_fix = neg_r ? -rem_next : rem_next;
  end

  always_comb begin
    stallreq_o = 1'b0;
    if (!annul_i) begin
      stallreq_o = ((state == IDLE) && start_i) || (state == BYZERO) || (state == RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || annul_i) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      dvd_raw  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      ready_q  <= 1'b0;
      result_q <= '0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (div_zero) begin
              dvd_raw <= opdata1_i;
              state   <= BYZERO;
            end else if (early_out) begin
              result_q <= {opdata1_i, {WIDTH{1'b0}}};
              ready_q  <= 1'b1;
              state    <= DONE;
            end else begin
              quo   <= mag_dvd;
              dvs   <= mag_dvs;
              rem   <= '0;
              cnt   <= '0;
              neg_q <= sign_dvd ^ sign_dvs;
              neg_r <= sign_dvd;
              state <= RUN;
            end
          end
        end
        BYZERO: begin
          result_q <= {dvd_raw, {WIDTH{1'b1}}};
          ready_q  <= 1'b1;
          state    <= DONE;
        end
        RUN: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            result_q <= {rem_fix, quo_fix};
            ready_q  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          // a start_i seen here is the instruction completing now
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: unsigned/signed divides, divide by
// zero, annul, mid-operation reset, back-to-back issue and the early-out boundary.
module tb_div_seq;
  localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = W + 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i;
  logic           signed_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic           annul_i;
  logic           stallreq_o;
  logic           ready_o;
  logic [2*W-1:0] result_o;

  int n_cmp = 0;
  int n_bad = 0;

  div_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .annul_i    (annul_i),
    .stallreq_o (stallreq_o),
    .ready_o    (ready_o),
    .result_o   (result_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic s, input logic sg, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic an);
    start_i   = s;
    signed_i  = sg;
    opdata1_i = a;
    opdata2_i = b;
    annul_i   = an;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues a divide in the current cycle, holding start_i through DONE as EX would.
  task automatic run_div(input string name, input logic sg, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int lat, input logic [2*W-1:0] exp);
    for (int k = 0; k <= lat; k++) begin
      drive(1'b1, sg, a, b, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (stallreq_o !== (k < lat)) begin
        n_bad++;
        $display("FAIL %s stall k=%0d: got %b want %b", name, k, stallreq_o, (k < lat));
      end
      n_cmp++;
      if (ready_o !== (k == lat)) begin
        n_bad++;
        $display("FAIL %s ready k=%0d: got %b want %b", name, k, ready_o, (k == lat));
      end
      n_cmp++;
      if (result_o !== ((k == lat) ? exp : '0)) begin
        n_bad++;
        $display("FAIL %s result k=%0d: got %h want %h", name, k, result_o,
                 ((k == lat) ? exp : '0));
      end
      step();
    end
  endtask

  task automatic expect_idle(input string name);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (stallreq_o !== 1'b0 || ready_o !== 1'b0 || result_o !== '0) begin
      n_bad++;
      $display("FAIL %s idle: got stall=%b ready=%b result=%h want 0/0/0", name,
               stallreq_o, ready_o, result_o);
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (stallreq_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset stall: got %b want 0", stallreq_o);
    end
    n_cmp++;
    if (ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset ready: got %b want 0", ready_o);
    end
    n_cmp++;
    if (result_o !== '0) begin
      n_bad++;
      $display("FAIL reset result: got %h want 0", result_o);
    end
    step();
  endtask

  task automatic test_divu();
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, W + 1, {32'd2, 32'd14});
    expect_idle("divu_100_7");
    run_div("divu_max_16", 1'b0, 32'hFFFFFFFF, 32'h10, W + 1, {32'hF, 32'h0FFFFFFF});
    expect_idle("divu_max_16");
    run_div("divu_7_7", 1'b0, 32'd7, 32'd7, W + 1, {32'd0, 32'd1});
    expect_idle("divu_7_7");
  endtask

  task automatic test_signed();
    run_div("div_m7_2", 1'b1, -32'sd7, 32'd2, W + 1, {32'hFFFFFFFF, 32'hFFFFFFFD});
    expect_idle("div_m7_2");
    run_div("div_7_m2", 1'b1, 32'd7, -32'sd2, W + 1, {32'h00000001, 32'hFFFFFFFD});
    expect_idle("div_7_m2");
    run_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, W + 1, {32'h0, 32'h80000000});
    expect_idle("div_min_m1");
  endtask

  task automatic test_byzero();
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 2, {32'd5, 32'hFFFFFFFF});
    expect_idle("divu_5_0");
    run_div("div_m5_0", 1'b1, -32'sd5, 32'd0, 2, {32'hFFFFFFFB, 32'hFFFFFFFF});
    expect_idle("div_m5_0");
  endtask

  task automatic test_early_out();
    run_div("div_m3_7", 1'b1, -32'sd3, 32'd7, EO_LAT, {32'hFFFFFFFD, 32'h0});
    expect_idle("div_m3_7");
  endtask

  task automatic test_annul();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (stallreq_o !== 1'b1 || ready_o !== 1'b0) begin
        n_bad++;
        $display("FAIL annul pre k=%0d: got stall=%b ready=%b want 1/0", k, stallreq_o, ready_o);
      end
      step();
    end
    drive(1'b1, 1'b0, 32'd100, 32'd7, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (stallreq_o !== 1'b0) begin
      n_bad++;
      $display("FAIL annul gate: got stall=%b want 0", stallreq_o);
    end
    step();
    expect_idle("annul_t11");
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, W + 1, {32'd0, 32'd3});
    expect_idle("divu_9_3");
  endtask

  task automatic test_back_to_back();
    run_div("b2b_20_4", 1'b0, 32'd20, 32'd4, W + 1, {32'd0, 32'd5});
    run_div("b2b_21_4", 1'b0, 32'd21, 32'd4, W + 1, {32'd1, 32'd5});
    expect_idle("b2b");
  endtask

  task automatic test_rst_mid();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
      step();
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    step();
    rst = 1'b0;
    for (int k = 6; k < 36; k++) begin
      @(negedge clk);
      n_cmp++;
      if (stallreq_o !== 1'b0 || ready_o !== 1'b0 || result_o !== '0) begin
        n_bad++;
        $display("FAIL rst_mid k=%0d: got stall=%b ready=%b result=%h want 0/0/0", k,
                 stallreq_o, ready_o, result_o);
      end
      step();
    end
    run_div("divu_8_2", 1'b0, 32'd8, 32'd2, W + 1, {32'd0, 32'd4});
    expect_idle("divu_8_2");
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_byzero();
    test_early_out();
    test_annul();
    test_back_to_back();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle sequencer for the iterative divider in the EX stage.
- Accepts a DIV/DIVU request from EX and runs a radix-2 restoring divide, one quotient bit per cycle.
- Holds the pipeline with a stall request, which pipeline control turns into a stall-bus pattern.
- Returns a 64-bit {remainder, quotient} result for the HI/LO write.

## Interface
- WIDTH, 32, operand width; the result is 2*WIDTH.

- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- start_i  in  1  EX holds a divide instruction
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU
- opdata1_i  in  WIDTH  dividend
- opdata2_i  in  WIDTH  divisor
- annul_i  in  1  flush of the EX instruction; aborts the operation
- stallreq_o  out  1  stall request toward pipeline control
- ready_o  out  1  result valid, single-cycle pulse
- result_o  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}

## Operation
- FSM states: IDLE, BYZERO, RUN, DONE. Reset sends the FSM to IDLE.
- IDLE, accepting a request (start_i=1 and annul_i=0):
  - If opdata2_i == 0, go to BYZERO.
  - Otherwise latch |dividend| and |divisor| (magnitudes taken only when signed_i=1), latch the operand signs, clear the partial remainder, clear counter cnt, and go to RUN.
- RUN iteration, one per cycle:
  - Shift {R, Q} left by 1, where R is the (WIDTH+1)-bit partial remainder.
  - Trial-subtract the divisor. If the result is non-negative, keep it and set Q[0]=1; otherwise restore and set Q[0]=0.
  - Increment cnt. After iteration WIDTH (cnt == WIDTH-1 at the cycle's end), go to DONE.
- Sign fixup on the DONE transition, signed only:
  - Negate the quotient when the operand signs differ.
  - The remainder takes the sign of the dividend.
  - 0x80000000 / -1 wraps: quotient 0x80000000, remainder 0.
- BYZERO: loads quotient = all ones and remainder = opdata1_i as latched (no sign processing), then goes to DONE.
- DONE:
  - ready_o=1, result_o valid.
  - Unconditional transition to IDLE.
  - start_i in DONE belongs to the instruction just completing and is ignored.
- result_o is 0 whenever ready_o=0.
- stallreq_o (combinational) = (IDLE & start_i & ~annul_i) | BYZERO | RUN, gated low whenever annul_i=1.
- annul_i=1 in any state: go to IDLE on the next edge. ready_o is never raised for the annulled operation, and latched state is discarded.
- rst=1 at an edge: state IDLE, registers 0. Mid-operation, rst behaves like annul_i; an in-flight result is lost.

## Timing
- Request accepted at cycle T (IDLE).
- Normal divide: RUN occupies T+1..T+WIDTH, DONE is T+WIDTH+1. stallreq_o is high T..T+WIDTH and low at T+WIDTH+1.
- Divide by zero: BYZERO at T+1, DONE at T+2. stallreq_o is high T..T+1.
- The stall drop in the DONE cycle lets EX advance at the end of DONE. A start_i in the following IDLE cycle is a new instruction, so back-to-back divides have no dead cycle beyond DONE.
- Output values after reset: stallreq_o=0, ready_o=0, result_o=0.

## Configuration
- DIV_EARLY_OUT_EN:
  - Defined: in IDLE, a non-zero divisor with |dividend| < |divisor| skips RUN. The FSM goes directly to DONE at T+1 with quotient 0 and remainder = the original dividend, sign preserved. stallreq_o is high only at T.
  - Undefined: every non-zero divide takes the full WIDTH iterations.

## Test plan
- DIVU 100/7 at T: stallreq_o high T..T+32; ready_o at T+33 with result_o = {32'd2, 32'd14}.
- DIV -7/2: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF gives {0, 0x80000000}.
- DIVU 5/0: ready_o at T+2 with {32'd5, 32'hFFFFFFFF}; stallreq_o low at T+2.
- Abort and restart:
  - annul_i pulsed at T+10: stallreq_o is 0 in that cycle, the FSM is IDLE at T+11, and no ready_o follows.
  - A DIVU 9/3 issued at T+12 completes at T+45 with {0, 3}.
- Back-to-back: DIVU 20/4 at T then 21/4 at T+34 give {0, 5} at T+33 and {1, 5} at T+67.
- rst at T+5 of a divide: all outputs 0 from T+6; a DIVU 8/2 issued next completes correctly with {0, 4}.
- With DIV_EARLY_OUT_EN defined, DIV -3/7: ready_o at T+1 with {0xFFFFFFFD, 0}.
